// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-anode, active-low multi-digit 7-segment display.
// Adds per-digit decimal points, leading-zero blanking, blinking and frame-synchronous data update.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]        prescaler_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [FRM_W-1:0]        frame_reg;
  logic                    blink_phase_reg;
  logic [4*NUM_DIGITS-1:0] active_bcd_reg;
  logic [NUM_DIGITS-1:0]   active_dp_reg;
  logic [NUM_DIGITS-1:0]   active_blink_reg;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic [NUM_DIGITS-1:0]   shadow_blink_reg;
  logic                    pending_reg;
  logic [7:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   an_reg;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              digit_code [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_run;
  logic [3:0]              cur_code;
  logic [6:0]              dec7;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign tick = (prescaler_reg == PRE_LAST);
  assign wrap = tick && (idx_reg == IDX_LAST);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_code[gi] = active_bcd_reg[4*gi +: 4];
  end

  // A digit is a leading zero when it and every more-significant digit are 0; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (digit_code[i] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end

  assign cur_code = digit_code[idx_reg];

  always_comb begin
    dec7 = 7'h7f;
    case (cur_code)
      4'h0: dec7 = 7'h40;
      4'h1: dec7 = 7'h79;
      4'h2: dec7 = 7'h24;
      4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19;
      4'h5: dec7 = 7'h12;
      4'h6: dec7 = 7'h02;
      4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00;
      4'h9: dec7 = 7'h10;
      4'hb: dec7 = 7'h03;
      4'hc: dec7 = 7'h46;
      4'hd: dec7 = 7'h21;
      4'he: dec7 = 7'h06;
      default: dec7 = 7'h7f;
    endcase
  end

  always_comb begin
    seg_next = {~active_dp_reg[idx_reg], dec7};
    if (blank_lz && lz_blank[idx_reg]) begin
      seg_next[6:0] = 7'h7f;
    end
    // Blink off-phase darkens the whole digit, decimal point included.
    if (active_blink_reg[idx_reg] && blink_phase_reg) begin
      seg_next = 8'hff;
    end
    an_next = ~(NUM_DIGITS'(1) << idx_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_reg    <= '0;
      idx_reg          <= '0;
      frame_reg        <= '0;
      blink_phase_reg  <= 1'b0;
      active_bcd_reg   <= {NUM_DIGITS{4'hf}};
      active_dp_reg    <= '0;
      active_blink_reg <= '0;
      shadow_bcd_reg   <= {NUM_DIGITS{4'hf}};
      shadow_dp_reg    <= '0;
      shadow_blink_reg <= '0;
      pending_reg      <= 1'b0;
      seg_reg          <= 8'hff;
      an_reg           <= '1;
    end else begin
      prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
      if (tick) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
      if (wrap) begin
        frame_reg <= (frame_reg == FRM_LAST) ? '0 : frame_reg + 1'b1;
        if (frame_reg == FRM_LAST) begin
          blink_phase_reg <= ~blink_phase_reg;
        end
      end

      if (load) begin
        shadow_bcd_reg   <= bcd_in;
        shadow_dp_reg    <= dp_in;
        shadow_blink_reg <= blink_mask;
      end
      // Active data only changes at the frame boundary so a frame never mixes old and new digits.
      if (wrap) begin
        if (load) begin
          active_bcd_reg   <= bcd_in;
          active_dp_reg    <= dp_in;
          active_blink_reg <= blink_mask;
        end else if (pending_reg) begin
          active_bcd_reg   <= shadow_bcd_reg;
          active_dp_reg    <= shadow_dp_reg;
          active_blink_reg <= shadow_blink_reg;
        end
        pending_reg <= 1'b0;
      end else if (load) begin
        pending_reg <= 1'b1;
      end

      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboarded bench for seg_scan_driver: a frame/slot-arithmetic reference model predicts
// every scan cycle, a separate monitor compares the registered seg/an outputs.
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int BF    = 2;
  localparam int FRAME = S * N;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;

  seg_scan_driver #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (S),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .blink_mask(blink_mask),
    .blank_lz  (blank_lz),
    .load      (load),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  logic [7:0] dec_tab [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                               8'h80, 8'h90, 8'hff, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'hff};

  // Reference model: data visible in the current frame, plus the not-yet-committed copy.
  logic [15:0] m_bcd, s_bcd;
  logic [3:0]  m_dp, m_bl, s_dp, s_bl;
  bit          m_pend;
  int          t;

  task automatic model_reset();
    m_bcd = 16'hffff; m_dp = '0; m_bl = '0;
    s_bcd = 16'hffff; s_dp = '0; s_bl = '0;
    m_pend = 1'b0;
    t = 0;
  endtask

  function automatic exp_t predict(int tt, logic lz);
    exp_t       e;
    int         slot, dig, phase;
    logic [3:0] code;
    bit         allz;
    slot  = tt / S;
    dig   = slot % N;
    phase = (slot / N / BF) % 2;
    code  = m_bcd[4*dig +: 4];
    e.seg = {~m_dp[dig], dec_tab[code][6:0]};
    if (lz && dig > 0) begin
      allz = 1'b1;
      for (int j = dig; j < N; j++) if (m_bcd[4*j +: 4] != 4'h0) allz = 1'b0;
      if (allz) e.seg[6:0] = 7'h7f;
    end
    if (m_bl[dig] && phase == 1) e.seg = 8'hff;
    e.an = 4'hf;
    e.an[dig] = 1'b0;
    e.t = tt;
    return e;
  endfunction

  // Called at a negedge: drive inputs for the next posedge, predict its output, advance model.
  task automatic step(input bit ld, input logic [15:0] b, input logic [3:0] d, input logic [3:0] bm);
    bit wrap;
    load = ld;
    if (ld) begin
      bcd_in = b; dp_in = d; blink_mask = bm;
    end
    sb.push_back(predict(t, blank_lz));
    wrap = ((t + 1) % FRAME) == 0;
    if (ld) $display("load t=%0d bcd=%h dp=%b blink=%b lz=%0b on_wrap=%0d", t, b, d, bm, blank_lz, wrap);
    if (wrap) begin
      if (ld) begin
        m_bcd = b; m_dp = d; m_bl = bm;
      end else if (m_pend) begin
        m_bcd = s_bcd; m_dp = s_dp; m_bl = s_bl;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      s_bcd = b; s_dp = d; s_bl = bm;
      m_pend = 1'b1;
    end
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, bcd_in, dp_in, blink_mask);
  endtask

  task automatic to_slot(input int k);
    while ((t % FRAME) != k) idle(1);
  endtask

  task automatic check_reset(input string nm);
    total++;
    if (seg !== 8'hff || an !== 4'hf) begin
      bad++;
      $display("FAIL %s seg=%h an=%b want seg=ff an=1111", nm, seg, an);
    end
  endtask

  task automatic rand_run(input int n);
    repeat (n) begin
      if ($urandom_range(0, 199) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 15) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      else
        idle(1);
    end
  endtask

  // Monitor: one comparison per scan cycle that the driver predicted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (an !== e.an || seg !== e.seg) begin
          bad++;
          $display("FAIL scan t=%0d an=%b seg=%h want an=%b seg=%h", e.t, an, seg, e.an, e.seg);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    idle(40);

    to_slot(5);
    step(1'b1, 16'h0123, 4'h0, 4'h0);
    idle(2 * FRAME);
    to_slot(5);
    step(1'b1, 16'h4567, 4'h0, 4'h0);
    idle(2 * FRAME);
    to_slot(FRAME - 1);
    step(1'b1, 16'h89ab, 4'b1010, 4'h0);
    idle(FRAME);
    to_slot(3);
    step(1'b1, 16'hcdef, 4'b0001, 4'h0);
    idle(2 * FRAME);
    to_slot(2);
    step(1'b1, 16'h1234, 4'h0, 4'h0);
    idle(3);
    step(1'b1, 16'h5678, 4'b1000, 4'h0);
    idle(2 * FRAME);

    blank_lz = 1'b1;
    to_slot(0);
    step(1'b1, 16'h0050, 4'b0100, 4'h0);
    idle(2 * FRAME);
    step(1'b1, 16'h0000, 4'h0, 4'h0);
    idle(2 * FRAME);
    blank_lz = 1'b0;
    idle(FRAME);

    to_slot(0);
    step(1'b1, 16'h1111, 4'h0, 4'b0001);
    idle(6 * FRAME);

    rand_run(1200);

    load = 1'b0;
    to_slot(9);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("async_reset_mid_frame");
    repeat (2) @(negedge clk);
    check_reset("async_reset_held");
    reset_n = 1'b1;
    model_reset();
    blank_lz = 1'b0;
    idle(40);
    rand_run(300);

    load = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
